// File: rtl/signed_divider_pkg.sv
// Shared types for the signed restoring divider: control states and the
// control bundle the FSM hands to the datapath each cycle.
package signed_divider_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic capture;
        logic load;
        logic step;
        logic accept_sub;
        logic fix;
        logic zero_div;
    } ctrl_t;

endpackage

// File: rtl/signed_divider_datapath.sv
// Operand/result registers, restoring subtractor, iteration counter and sign
// handling for the signed divider; sequenced entirely by the ctrl bundle.
module signed_divider_datapath
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  ctrl_t            ctrl,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow,
    output logic             cnt_zero,
    output logic             sub_neg,
    output logic             divisor_is_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] qmag, bmag;
    logic [WIDTH:0]   prem;
    logic [CW-1:0]    cnt;
    logic             qneg, rneg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;

    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is the
    // correct unsigned magnitude, so no special case is needed here.
    assign a_mag   = a_reg[WIDTH-1] ? -a_reg : a_reg;
    assign b_mag   = b_reg[WIDTH-1] ? -b_reg : b_reg;
    assign shifted = {prem[WIDTH-1:0], qmag[WIDTH-1]};
    assign diff    = shifted - {1'b0, bmag};

    assign sub_neg         = diff[WIDTH];
    assign cnt_zero        = (cnt == '0);
    assign divisor_is_zero = (b_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            qmag      <= '0;
            bmag      <= '0;
            prem      <= '0;
            cnt       <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (ctrl.capture) begin
                a_reg    <= dividend;
                b_reg    <= divisor;
                div_zero <= 1'b0;
                overflow <= 1'b0;
            end
            if (ctrl.load) begin
                qmag <= a_mag;
                bmag <= b_mag;
                prem <= '0;
                cnt  <= CW'(WIDTH - 1);
                qneg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                rneg <= a_reg[WIDTH-1];
            end
            if (ctrl.zero_div) begin
                quotient  <= '1;
                remainder <= a_reg;
                div_zero  <= 1'b1;
            end
            // The dividend magnitude shifts out of qmag as quotient bits shift in.
            if (ctrl.step) begin
                prem <= ctrl.accept_sub ? diff : shifted;
                qmag <= {qmag[WIDTH-2:0], ctrl.accept_sub};
                cnt  <= cnt - 1'b1;
            end
            if (ctrl.fix) begin
                quotient  <= qneg ? -qmag : qmag;
                remainder <= rneg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                overflow  <= (a_reg == MOST_NEG) && (b_reg == '1);
            end
        end
    end

endmodule

// File: rtl/signed_divider.sv
// Signed multi-cycle divider: control FSM sequencing the restoring datapath
// through LOAD, WIDTH iteration steps and the sign fix-up.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_zero,
    output logic             overflow
);

    state_t state, next_state;
    ctrl_t  ctrl;
    logic   cnt_zero, sub_neg, divisor_is_zero;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ctrl.capture = 1'b1;
                    next_state   = LOAD;
                end
            end
            LOAD: begin
                if (divisor_is_zero) begin
                    ctrl.zero_div = 1'b1;
                    next_state    = DONE;
                end else begin
                    ctrl.load  = 1'b1;
                    next_state = ITER;
                end
            end
            ITER: begin
                ctrl.step       = 1'b1;
                ctrl.accept_sub = !sub_neg;
                if (cnt_zero) next_state = FIX;
            end
            FIX: begin
                ctrl.fix   = 1'b1;
                next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign done = (state == DONE);
    assign busy = (state == LOAD) || (state == ITER) || (state == FIX);

    signed_divider_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk             (clk),
        .reset           (reset),
        .ctrl            (ctrl),
        .dividend        (dividend),
        .divisor         (divisor),
        .quotient        (quotient),
        .remainder       (remainder),
        .div_zero        (div_zero),
        .overflow        (overflow),
        .cnt_zero        (cnt_zero),
        .sub_neg         (sub_neg),
        .divisor_is_zero (divisor_is_zero)
    );

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (WIDTH=8): directed vector table,
// hand-written corner sequences and random operands against an integer model.
module tb_signed_divider;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic       done, busy, div_zero, overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       dz, ov;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    signed_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference from plain integer arithmetic: truncating division, remainder
    // takes the dividend's sign; divide-by-zero and overflow handled explicitly.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0; ov = 1'b0; lat = 11;
        if (sb == 0) begin
            q = 8'hFF; r = a; dz = 1'b1; lat = 2;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80; r = 8'h00; ov = 1'b1;
        end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
    endtask

    // Starts a division and returns the cycle in which done first rose
    // (accept edge = edge 0, the following period = cycle 1); 0 on timeout.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        checkOutput("done cleared on accept", {31'd0, done}, 32'd0);
        checkOutput("busy in cycle 1", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k + 1;
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] a, input logic [7:0] b, input int lat);
        logic [7:0] q, r;
        logic       dz, ov;
        int         elat;
        model(a, b, q, r, dz, ov, elat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
        checkOutput({tag, " quotient"}, {24'd0, quotient}, {24'd0, q});
        checkOutput({tag, " remainder"}, {24'd0, remainder}, {24'd0, r});
        checkOutput({tag, " flags"}, {30'd0, div_zero, overflow}, {30'd0, dz, ov});
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb, hq, hr;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", {quotient, remainder, 12'd0, done, busy, div_zero, overflow}, 32'd0);
        @(negedge clk); reset = 1'b0;

        vecs.push_back('{8'd100, 8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h9C,  8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0, 11});
        vecs.push_back('{8'd100, 8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h80,  8'hFF,   8'h80, 8'h00, 1'b0, 1'b1, 11});
        vecs.push_back('{8'd5,   8'd0,    8'hFF, 8'h05, 1'b1, 1'b0, 2});
        vecs.push_back('{8'd0,   8'd5,    8'h00, 8'h00, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h80,  8'd1,    8'h80, 8'h00, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h7F,  8'h80,   8'h00, 8'h7F, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h80,  8'h80,   8'h01, 8'h00, 1'b0, 1'b0, 11});
        vecs.push_back('{8'hFF,  8'd2,    8'h00, 8'hFF, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h80,  8'd0,    8'hFF, 8'h80, 1'b1, 1'b0, 2});
        vecs.push_back('{8'h80,  8'd7,    8'hEE, 8'hFE, 1'b0, 1'b0, 11});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d quotient", i), {24'd0, quotient}, {24'd0, vecs[i].q});
            checkOutput($sformatf("vec%0d remainder", i), {24'd0, remainder}, {24'd0, vecs[i].r});
            checkOutput($sformatf("vec%0d flags", i), {30'd0, div_zero, overflow}, {30'd0, vecs[i].dz, vecs[i].ov});
        end

        // Results must hold while idling in DONE.
        hq = quotient; hr = remainder;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("hold in DONE", {16'd0, quotient, remainder, 6'd0, done, busy}, {16'd0, hq, hr, 8'b10});

        // Start pulsed mid-ITER with new operands must be ignored.
        @(negedge clk); start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; dividend = 8'd3; divisor = 8'd1;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        for (int k = 5; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k + 1;
        end
        checkResult("ignored start", 8'd100, 8'd7, lat);

        // Reset while in ITER cycle 4, then a fresh division.
        @(negedge clk); start = 1'b1; dividend = 8'd99; divisor = 8'd4;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset mid-ITER", {quotient, remainder, 12'd0, done, busy, div_zero, overflow}, 32'd0);
        @(negedge clk); reset = 1'b0;
        applyStimulus(8'd50, 8'd5, lat);
        checkResult("after reset 50/5", 8'd50, 8'd5, lat);

        // Reset wins over a simultaneous start.
        @(negedge clk); reset = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset over start", {30'd0, busy, done}, 32'd0);

        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 25 == 0) rb = 8'd0;
            if (n % 40 == 1) begin ra = 8'h80; rb = 8'hFF; end
            applyStimulus(ra, rb, lat);
            checkResult($sformatf("rand %0h/%0h", ra, rb), ra, rb, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
